mips_dmem_responder: RTL and testbench
======================================

Name: mips_dmem_responder

Overview:
Data-side responder for the single-cycle MIPS core. It sits on the core's data interface (MemWrite, DataAddr, WriteData, ReadData) and services every load and store.
- Addresses below 0xFFFF_0000 go to a word-addressed data RAM.
- Addresses in 0xFFFF_0000–0xFFFF_000F hit memory-mapped registers: a result mailbox, a cycle counter, a TX FIFO and a status word.
- The TX FIFO drains through a valid/ready byte stream, so programs can report pass/fail and print characters without bench address snooping.

Parameters:
ADDR_W, 6, RAM word-address width (RAM depth = 2^ADDR_W words)
FIFO_DEPTH, 4, TX FIFO entries, power of two, ≥2
MMIO_BASE, 32'hFFFF_0000, base of the 16-byte register window

Ports:
clk  in  1  rising-edge clock shared with the core
reset  in  1  asynchronous, active-high reset
MemWrite  in  1  store strobe from core, sampled on rising clk
DataAddr  in  32  byte address from core (bits [1:0] ignored)
WriteData  in  32  store data from core
ReadData  out  32  load data, combinational from DataAddr
TxData  out  8  head byte of TX FIFO
TxValid  out  1  FIFO non-empty
TxReady  in  1  consumer accepts TxData when TxValid & TxReady at rising clk
Done  out  1  sticky: result mailbox has been written
Result  out  32  last value written to the mailbox

Behaviour:
- Reset (async, active-high):
  - Done=0, Result=0, cycle counter=0, FIFO empty (TxValid=0, TxData=0), Overflow=0.
  - RAM contents are not reset.
- Decode:
  - MMIO hit when DataAddr[31:4] == MMIO_BASE[31:4]; register index = DataAddr[3:2].
  - Otherwise RAM, index = DataAddr[ADDR_W+1:2]; upper bits are aliased, not checked.
- RAM:
  - Write on rising clk when MemWrite & ~MMIO hit.
  - Read is combinational, zero latency (single-cycle core requirement).
  - A load from the address being written in the same cycle returns the old value.
- MMIO index 0, RESULT:
  - Write: Result <= WriteData, Done <= 1.
  - Later writes update Result; Done stays 1 until reset.
  - Read returns Result.
- MMIO index 1, CYCLE:
  - Read-only free-running 32-bit counter; +1 every clk while Done==0, frozen once Done==1.
  - Wraps 0xFFFF_FFFF -> 0.
  - Writes are ignored.
- MMIO index 2, TXDATA:
  - Write pushes WriteData[7:0].
  - If the FIFO is full and no pop happens that cycle, the byte is dropped and Overflow <= 1 (sticky until reset).
  - Read returns 0.
- MMIO index 3, STATUS:
  - Read returns {28'b0, Overflow, full, ~TxValid, Done}.
  - Writes are ignored.
- FIFO:
  - Pop when TxValid & TxReady.
  - Push and pop in the same cycle are both performed; when full this is not an overflow and the count is unchanged.
  - TxData = head entry (0 when empty); count range 0..FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
  - TxValid and TxData change only on clk edges (registered state); TxData is stable while TxValid & ~TxReady.
- Reset asserted mid-stream: FIFO flushed immediately, TxValid drops asynchronously, and any byte being transferred is lost.
- Rule on MemWrite: sampled only on a clk edge. No X propagation from DataAddr when MemWrite=0 is allowed to alter state.

Test Plan:
- Reset, then store 7 to addr 0x0 and load 0x0 -> RAM returns 7; Done stays 0; the same RAM word also aliases at 0x100 (ADDR_W=6).
- Hold TxReady=1, 5 idle cycles, read 0xFFFF_0004 -> 5. Write 0x2A to 0xFFFF_0000 -> Done=1, Result=0x2A. Read CYCLE over 3 more cycles -> value constant.
- Hold TxReady=0, store 'A','B','C','D','E' to 0xFFFF_0008 -> 4 queued, 'E' dropped. Read 0xFFFF_000C -> 0xC (Overflow=1, full=1, TxValid=1, Done=0). Then raise TxReady -> TxData sequence 0x41,0x42,0x43,0x44 on 4 consecutive edges, then TxValid=0.
- FIFO full, TxReady=1 and push 'Z' in the same cycle -> no overflow, count stays 4, 'Z' emerges last.
- Assert reset for 1 ns mid-drain with 2 bytes queued -> TxValid=0, Done=0 and counter=0 immediately. After release, STATUS reads 0x2 (empty, no overflow).
- Load from unmapped index writes (index 3 write, then index 1 write of 0xFFFF) -> STATUS and CYCLE unchanged by the writes; TXDATA read returns 0.

Source files
------------

// File: rtl/mips_dmem_responder_if.sv
// Data-side bus between the single-cycle MIPS core and its memory responder.
// Carries the load/store port and the TX byte stream that drains the console FIFO.
//   MemWrite  : store strobe from the core, sampled on the rising clock
//   DataAddr  : byte address from the core
//   WriteData : store data from the core
//   ReadData  : combinational load data back to the core
//   TxData    : head byte of the TX FIFO
//   TxValid   : TX FIFO holds at least one byte
//   TxReady   : consumer takes TxData when TxValid & TxReady at a rising clock
// The master modport is the core/consumer side; the slave modport is the responder.
`timescale 1ns/1ps

interface mips_dmem_responder_if;
  logic        MemWrite;
  logic [31:0] DataAddr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;

  modport master (
    output MemWrite, DataAddr, WriteData, TxReady,
    input  ReadData, TxData, TxValid
  );

  modport slave (
    input  MemWrite, DataAddr, WriteData, TxReady,
    output ReadData, TxData, TxValid
  );
endinterface

// File: rtl/mips_dmem_responder.sv
// Data memory responder for the single-cycle MIPS core.
// Services every load and store: ordinary addresses land in a word-addressed
// RAM, and a 16-byte window at MMIO_BASE exposes a result mailbox, a cycle
// counter, a TX byte FIFO and a status word.
//   clk    : rising-edge clock shared with the core
//   reset  : asynchronous, active-high reset
//   bus    : slave side of the load/store port and the TX byte stream
//   Done   : sticky flag, set once the result mailbox has been written
//   Result : last value written to the result mailbox
`timescale 1ns/1ps

module mips_dmem_responder #(
  parameter int          ADDR_W     = 6,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_dmem_responder_if.slave  bus,
  output logic                  Done,
  output logic [31:0]           Result
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  // Register index inside the MMIO window (word offset within 16 bytes).
  typedef enum logic [1:0] {
    REG_RESULT = 2'd0,
    REG_CYCLE  = 2'd1,
    REG_TXDATA = 2'd2,
    REG_STATUS = 2'd3
  } regIdx_e;

  logic              mmioHit;
  regIdx_e           regIdx;
  logic [ADDR_W-1:0] ramIdx;
  logic              ramWe;
  logic              resultWe;
  logic              txPush;
  logic              txPop;
  logic              txPushOk;
  logic              txFull;
  logic              txEmpty;
  logic              overflow;
  logic [31:0]       cycleCount;
  logic [31:0]       statusWord;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [CNT_W-1:0]  txCount;
  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [31:0]       ram [2**ADDR_W];
  logic              unusedAddrBits;

  // Byte-lane bits never matter: every access is a full word.
  assign unusedAddrBits = ^bus.DataAddr[1:0];

  // Address decode. RAM upper address bits are deliberately aliased, so only
  // the low ADDR_W word bits pick a RAM entry.
  assign mmioHit = (bus.DataAddr[31:4] == MMIO_BASE[31:4]);
  assign regIdx  = regIdx_e'(bus.DataAddr[3:2]);
  assign ramIdx  = bus.DataAddr[ADDR_W+1:2];

  // Every write enable is qualified by MemWrite first, so an undriven address
  // while the core is not storing cannot disturb any state.
  assign ramWe    = bus.MemWrite && !mmioHit;
  assign resultWe = bus.MemWrite && mmioHit && (regIdx == REG_RESULT);
  assign txPush   = bus.MemWrite && mmioHit && (regIdx == REG_TXDATA);

  // FIFO flags come straight from the registered count, so TxValid and TxData
  // only move on clock edges (or asynchronously on reset).
  assign txEmpty  = (txCount == '0);
  assign txFull   = (txCount == FULL_COUNT);
  assign txPop    = !txEmpty && bus.TxReady;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign txPushOk = txPush && (!txFull || txPop);

  assign bus.TxValid = !txEmpty;
  assign bus.TxData  = txEmpty ? 8'h00 : fifoMem[rdPtr];

  assign statusWord = {28'b0, overflow, txFull, txEmpty, Done};

  // Word RAM with a synchronous write and no reset; the combinational read
  // below sees the pre-edge contents, so a same-cycle load returns old data.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      ram[ramIdx] <= bus.WriteData;
    end
  end

  // Result mailbox: every write updates Result, and Done latches until reset
  // so the bench can stop on the first report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Done   <= 1'b0;
      Result <= '0;
    end else if (resultWe) begin
      Done   <= 1'b1;
      Result <= bus.WriteData;
    end
  end

  // Free-running cycle counter that freezes once the program reports, giving
  // the program's run length. Wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCount <= '0;
    end else if (!Done) begin
      cycleCount <= cycleCount + 32'd1;
    end
  end

  // TX FIFO: circular buffer with power-of-two pointers that wrap on their own.
  // A push that finds the FIFO full with no simultaneous pop is dropped and
  // recorded in the sticky overflow flag. Reset flushes everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      txCount  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoMem[i] <= 8'h00;
      end
    end else begin
      if (txPushOk) begin
        fifoMem[wrPtr] <= bus.WriteData[7:0];
        wrPtr          <= wrPtr + PTR_W'(1);
      end else if (txPush) begin
        overflow <= 1'b1;
      end
      if (txPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      txCount <= txCount + CNT_W'(txPushOk) - CNT_W'(txPop);
    end
  end

  // Load data path: zero-latency mux between the MMIO registers and the RAM.
  always_comb begin
    bus.ReadData = '0;
    if (mmioHit) begin
      case (regIdx)
        REG_RESULT: bus.ReadData = Result;
        REG_CYCLE:  bus.ReadData = cycleCount;
        REG_TXDATA: bus.ReadData = '0;
        REG_STATUS: bus.ReadData = statusWord;
        default:    bus.ReadData = '0;
      endcase
    end else begin
      bus.ReadData = ram[ramIdx];
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench for mips_dmem_responder.
// Stimulus tasks drive the core-side bus and queue the expected observations;
// a monitor process drains those queues and compares against the DUT on every
// falling clock edge (or on demand during a mid-cycle reset pulse).
`timescale 1ns/1ps

module tb_mips_dmem_responder;

  localparam int K_RD      = 0;
  localparam int K_DONE    = 1;
  localparam int K_RESULT  = 2;
  localparam int K_TXVALID = 3;
  localparam int K_TXDATA  = 4;

  localparam logic [31:0] A_RESULT = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } obs_t;

  logic        clk;
  logic        reset;
  logic        done;
  logic [31:0] result;
  logic        sampleReq;

  obs_t        obsQ[$];
  logic [7:0]  txQ[$];
  int          total;
  int          bad;

  mips_dmem_responder_if bus();

  mips_dmem_responder #(
    .ADDR_W    (6),
    .FIFO_DEPTH(4),
    .MMIO_BASE (32'hFFFF_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .Done  (done),
    .Result(result)
  );

  // 100 MHz clock, rising edges at 5, 15, 25 ns ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_RD:      return bus.ReadData;
      K_DONE:    return {31'b0, done};
      K_RESULT:  return result;
      K_TXVALID: return {31'b0, bus.TxValid};
      K_TXDATA:  return {24'b0, bus.TxData};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: drains queued expectations and checks every accepted TX byte
  // against the order in which the stimulus pushed it.
  initial begin
    obs_t        o;
    logic [31:0] act;
    logic [7:0]  expByte;
    forever begin
      @(negedge clk or posedge sampleReq);
      while (obsQ.size() > 0) begin
        o   = obsQ.pop_front();
        act = observe(o.kind);
        total++;
        if (act !== o.exp) begin
          bad++;
          $display("[TB] FAIL %s: got %h expected %h at %0t", o.name, act, o.exp, $time);
        end
      end
      if (bus.TxValid === 1'b1 && bus.TxReady === 1'b1) begin
        total++;
        if (txQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL txUnexpected: got %h expected no byte at %0t", bus.TxData, $time);
        end else begin
          expByte = txQ.pop_front();
          if (bus.TxData !== expByte) begin
            bad++;
            $display("[TB] FAIL txByte: got %h expected %h at %0t", bus.TxData, expByte, $time);
          end
        end
      end
    end
  end

  // One core cycle: drive the bus just after the rising edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    bus.MemWrite  = we;
    bus.DataAddr  = addr;
    bus.WriteData = data;
  endtask

  // Queue an expectation for the monitor's next sample.
  task automatic checkOutput(input int kind, input logic [31:0] exp, input string name);
    obs_t o;
    o.name = name;
    o.kind = kind;
    o.exp  = exp;
    obsQ.push_back(o);
  endtask

  task automatic pushTx(input logic [7:0] b, input logic expectKept);
    applyStimulus(1'b1, A_TXDATA, {24'h0, b});
    if (expectKept) txQ.push_back(b);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
    reset        = 1'b1;
    txQ.delete();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    sampleReq     = 1'b0;
    reset         = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.DataAddr  = A_STATUS;
    bus.WriteData = '0;
    bus.TxReady   = 1'b0;

    // Reset state, sampled at the 10 ns falling edge while reset is held.
    #1;
    checkOutput(K_DONE,    32'h0, "rstDone");
    checkOutput(K_RESULT,  32'h0, "rstResult");
    checkOutput(K_TXVALID, 32'h0, "rstTxValid");
    checkOutput(K_TXDATA,  32'h0, "rstTxData");
    checkOutput(K_RD,      32'h2, "rstStatus");
    #11;
    reset = 1'b0;

    // RAM store/load, aliasing and read-before-write.
    applyStimulus(1'b1, 32'h0, 32'h7);
    checkOutput(K_DONE, 32'h0, "ramDoneLow");
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput(K_RD, 32'h7, "ramRead");
    applyStimulus(1'b0, 32'h100, 32'h0);
    checkOutput(K_RD, 32'h7, "ramAlias");
    applyStimulus(1'b1, 32'h4, 32'h55);
    applyStimulus(1'b0, 32'h4, 32'h0);
    checkOutput(K_RD, 32'h55, "ramWord1");
    applyStimulus(1'b1, 32'h0, 32'h9);
    checkOutput(K_RD, 32'h7, "ramOldValue");
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput(K_RD, 32'h9, "ramNewValue");

    // Cycle counter runs until the mailbox is written, then freezes.
    doReset();
    bus.TxReady = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, A_CYCLE, 32'h0);
    checkOutput(K_RD, 32'd5, "cycleFive");
    applyStimulus(1'b1, A_RESULT, 32'h2A);
    checkOutput(K_RD,   32'h0, "resultBefore");
    checkOutput(K_DONE, 32'h0, "doneBefore");
    applyStimulus(1'b0, A_CYCLE, 32'h0);
    checkOutput(K_RD,     32'd7,  "cycleFrozen0");
    checkOutput(K_DONE,   32'h1,  "doneSet");
    checkOutput(K_RESULT, 32'h2A, "resultSet");
    applyStimulus(1'b0, A_CYCLE, 32'h0);
    checkOutput(K_RD, 32'd7, "cycleFrozen1");
    applyStimulus(1'b0, A_CYCLE, 32'h0);
    checkOutput(K_RD, 32'd7, "cycleFrozen2");
    applyStimulus(1'b1, A_RESULT, 32'h33);
    checkOutput(K_RD, 32'h2A, "resultReadback");
    applyStimulus(1'b0, A_RESULT, 32'h0);
    checkOutput(K_RD,   32'h33, "resultUpdate");
    checkOutput(K_DONE, 32'h1,  "doneSticky");

    // Overflow: five pushes into a stalled four-entry FIFO, then drain.
    doReset();
    bus.TxReady = 1'b0;
    pushTx(8'h41, 1'b1);
    pushTx(8'h42, 1'b1);
    pushTx(8'h43, 1'b1);
    pushTx(8'h44, 1'b1);
    pushTx(8'h45, 1'b0);
    applyStimulus(1'b0, A_STATUS, 32'h0);
    checkOutput(K_RD,      32'hC,  "statusOverflow");
    checkOutput(K_TXDATA,  32'h41, "txHeadStable");
    checkOutput(K_TXVALID, 32'h1,  "txValidFull");
    bus.TxReady = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, A_STATUS, 32'h0);
    checkOutput(K_TXVALID, 32'h0, "txDrained");
    checkOutput(K_RD,      32'hA, "statusStickyOvf");

    // Push and pop on the same edge while full is not an overflow.
    doReset();
    bus.TxReady = 1'b0;
    pushTx(8'h31, 1'b1);
    pushTx(8'h32, 1'b1);
    pushTx(8'h33, 1'b1);
    pushTx(8'h34, 1'b1);
    pushTx(8'h5A, 1'b1);
    bus.TxReady = 1'b1;
    applyStimulus(1'b0, A_STATUS, 32'h0);
    checkOutput(K_RD, 32'h4, "statusFullNoOvf");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, A_STATUS, 32'h0);
    checkOutput(K_TXVALID, 32'h0, "txDrainedZ");
    checkOutput(K_RD,      32'h2, "statusEmpty");

    // Reset pulse in the middle of a drain flushes the FIFO at once.
    doReset();
    bus.TxReady = 1'b0;
    applyStimulus(1'b1, A_RESULT, 32'h1);
    pushTx(8'h50, 1'b1);
    pushTx(8'h51, 1'b0);
    pushTx(8'h52, 1'b0);
    applyStimulus(1'b0, A_CYCLE, 32'h0);
    bus.TxReady = 1'b1;
    checkOutput(K_DONE, 32'h1, "doneBeforeReset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput(K_TXVALID, 32'h0, "midResetTxValid");
    checkOutput(K_DONE,    32'h0, "midResetDone");
    checkOutput(K_RESULT,  32'h0, "midResetResult");
    checkOutput(K_RD,      32'h0, "midResetCycle");
    #0.5;
    sampleReq = 1'b1;
    #0.5;
    sampleReq = 1'b0;
    reset     = 1'b0;
    bus.TxReady = 1'b0;
    applyStimulus(1'b0, A_STATUS, 32'h0);
    checkOutput(K_RD,      32'h2, "statusAfterReset");
    checkOutput(K_TXVALID, 32'h0, "txValidAfterReset");

    // Writes to read-only registers change nothing, and never reach RAM.
    doReset();
    bus.TxReady = 1'b0;
    applyStimulus(1'b1, 32'hC, 32'h22);
    applyStimulus(1'b1, A_STATUS, 32'hFFFF_FFFF);
    applyStimulus(1'b1, A_CYCLE, 32'h0000_FFFF);
    applyStimulus(1'b0, A_CYCLE, 32'h0);
    checkOutput(K_RD, 32'd4, "cycleIgnoresWrite");
    applyStimulus(1'b0, A_STATUS, 32'h0);
    checkOutput(K_RD, 32'h2, "statusIgnoresWrite");
    applyStimulus(1'b0, A_TXDATA, 32'h0);
    checkOutput(K_RD, 32'h0, "txDataReadsZero");
    applyStimulus(1'b0, 32'hC, 32'h0);
    checkOutput(K_RD, 32'h22, "ramNotHitByStatus");
    applyStimulus(1'b0, 32'h4, 32'h0);
    checkOutput(K_RD, 32'h55, "ramNotHitByCycle");

    applyStimulus(1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0);

    total++;
    if (txQ.size() != 0 || obsQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL leftover: got %0d tx %0d obs pending expected 0 0", txQ.size(), obsQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
